// File: rtl/reg_word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and the
// counter-width helper used by the top level and the beat counter.
package reg_word_serializer_pkg;

  typedef enum logic {
    RS_IDLE  = 1'b0,
    RS_SHIFT = 1'b1
  } rs_state_e;

  // ceil(log2(n)) with a floor of 1 so a single-beat word still has a counter bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_word_serializer_if.sv
// Stream bundle for the word serializer.
//   in_data/in_valid/in_ready     : parallel word input handshake
//   out_data/out_valid/out_ready  : serial beat output handshake
//   out_last                      : final beat of the current word
//   busy                          : a word is being drained
// slave = serializer side, master = producer/consumer side.
interface reg_word_serializer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SER_W = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [SER_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/reg_word_serializer_beat_counter.sv
// Beat index within the word being drained.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart at beat 0 (word load)
//   inc        : advance one beat (non-final beat accepted)
//   count      : current beat index
//   is_last    : current beat is the final one of the word
module ser_beat_counter
  import reg_word_serializer_pkg::*;
#(
  parameter int unsigned BEATS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         inc,
  output logic [clog2_min1(BEATS)-1:0] count,
  output logic                         is_last
);
  localparam int unsigned CW = clog2_min1(BEATS);

  logic [CW-1:0] r_count;

  // Never increments past the last beat; only a load returns it to 0
  always_ff @(posedge clk) begin
    if (reset)    r_count <= '0;
    else if (clr) r_count <= '0;
    else if (inc) r_count <= r_count + CW'(1);
  end

  assign count   = r_count;
  assign is_last = (r_count == CW'(BEATS - 1));
endmodule

// File: rtl/reg_word_serializer.sv
// Parallel-to-serial word drain: loads a WIDTH-bit word and emits it as
// SER_W-bit beats, LSB beat first, with out_last on the final beat.
// A new word may load in the same cycle the final beat is accepted.
//   clk, reset : clock and synchronous active-high reset
//   bus        : stream bundle (slave side), see reg_word_serializer_if
module reg_word_serializer
  import reg_word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SER_W = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_word_serializer_if.slave  bus
);
  localparam int unsigned BEATS = WIDTH / SER_W;
  localparam int unsigned CW    = clog2_min1(BEATS);

  rs_state_e        r_state;
  rs_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    w_count;
  logic             w_is_last;
  logic             w_ready_raw;
  logic             w_in_ready;
  logic             w_load;
  logic             w_shift;
  logic             w_out_valid;

  ser_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_load),
    .inc     (w_shift),
    .count   (w_count),
    .is_last (w_is_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RS_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_ready_raw = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      RS_IDLE: begin
        w_ready_raw = 1'b1;
        if (bus.in_valid) w_state_nxt = RS_SHIFT;
      end
      RS_SHIFT: begin
        if (bus.out_ready) begin
          if (w_is_last) begin
            // Final beat leaves: accept the next word now to avoid a bubble
            w_ready_raw = 1'b1;
            if (!bus.in_valid) w_state_nxt = RS_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_in_ready = w_ready_raw & ~reset;
  assign w_load     = w_in_ready & bus.in_valid;

  // Shift register: load on accept, zero-filled right shift per non-final beat
  always_ff @(posedge clk) begin
    if (reset)        r_shreg <= '0;
    else if (w_load)  r_shreg <= bus.in_data;
    else if (w_shift) r_shreg <= r_shreg >> SER_W;
  end

  assign w_out_valid   = (r_state == RS_SHIFT);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_out_valid;
  assign bus.out_data  = r_shreg[SER_W-1:0];
  assign bus.out_last  = w_out_valid & (w_count == CW'(BEATS - 1));
endmodule

// File: tb/tb_reg_word_serializer.sv
// Self-checking bench for reg_word_serializer: one SER_W=8 and one SER_W=1
// instance, driven one at a time through a shared driver, with expected
// beats computed arithmetically from each word.
module tb_reg_word_serializer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_word_serializer_if #(.WIDTH(32), .SER_W(8)) if8 ();
  reg_word_serializer_if #(.WIDTH(32), .SER_W(1)) if1 ();

  reg_word_serializer #(.WIDTH(32), .SER_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(if8));
  reg_word_serializer #(.WIDTH(32), .SER_W(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Shared driver, steered to one DUT by sel
  int          sel;
  logic        d_in_valid;
  logic [31:0] d_in_data;
  logic        d_out_ready;

  assign if8.in_data   = d_in_data;
  assign if1.in_data   = d_in_data;
  assign if8.in_valid  = d_in_valid & (sel == 0);
  assign if1.in_valid  = d_in_valid & (sel == 1);
  assign if8.out_ready = d_out_ready & (sel == 0);
  assign if1.out_ready = d_out_ready & (sel == 1);

  logic        s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [31:0] s_out_data;
  assign s_in_ready  = (sel == 0) ? if8.in_ready  : if1.in_ready;
  assign s_out_valid = (sel == 0) ? if8.out_valid : if1.out_valid;
  assign s_out_last  = (sel == 0) ? if8.out_last  : if1.out_last;
  assign s_busy      = (sel == 0) ? if8.busy      : if1.busy;
  assign s_out_data  = (sel == 0) ? 32'(if8.out_data) : 32'(if1.out_data);

  int checks = 0;
  int errors = 0;

  logic [31:0] words_q[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];

  int m_first_load, m_second_load, m_first_beat, m_first_last, m_last_beat, m_valid_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word split into serw-bit slices, lowest slice first
  task automatic model_word(input logic [31:0] word, input int serw);
    int    beats;
    beat_t b;
    logic [63:0] mask;
    beats = 32 / serw;
    mask  = (64'd1 << serw) - 64'd1;
    for (int i = 0; i < beats; i++) begin
      b.data = 32'((64'(word) >> (i * serw)) & mask);
      b.last = (i == beats - 1);
      exp_q.push_back(b);
    end
  endtask

  // mode 1: always ready; 2: ready pattern 1,0,0; 3: random valid/ready
  task automatic run(input string tag, input int sel_i, input int serw, input int mode, input int max_cyc);
    int    cyc, nloads;
    bit    done, stall;
    beat_t held, b;
    sel = sel_i;
    exp_q.delete();
    got_q.delete();
    foreach (words_q[i]) model_word(words_q[i], serw);
    m_first_load = -1; m_second_load = -1; m_first_beat = -1;
    m_first_last = -1; m_last_beat = -1; m_valid_cycles = 0;
    cyc = 0; nloads = 0; done = 0; stall = 0; held = '0;
    while (!done && cyc < max_cyc) begin
      @(posedge clk); #1;
      if (words_q.size() > 0 && (mode != 3 || $urandom_range(0, 9) < 7)) begin
        d_in_valid = 1'b1;
        d_in_data  = words_q[0];
      end else begin
        d_in_valid = 1'b0;
        d_in_data  = $urandom;
      end
      case (mode)
        1:       d_out_ready = 1'b1;
        2:       d_out_ready = ((cyc % 3) == 0);
        default: d_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (stall) begin
        check({tag, " stall valid"}, 32'(s_out_valid), 32'd1);
        check({tag, " stall data"},  s_out_data, held.data);
        check({tag, " stall last"},  32'(s_out_last), 32'(held.last));
      end
      stall     = s_out_valid && !d_out_ready;
      held.data = s_out_data;
      held.last = s_out_last;
      if (s_out_valid) begin
        m_valid_cycles++;
        if (m_first_beat < 0) m_first_beat = cyc;
      end
      if (d_in_valid && s_in_ready) begin
        void'(words_q.pop_front());
        nloads++;
        if (nloads == 1) m_first_load = cyc;
        if (nloads == 2) m_second_load = cyc;
      end
      if (s_out_valid && d_out_ready) begin
        b.data = s_out_data;
        b.last = s_out_last;
        got_q.push_back(b);
        m_last_beat = cyc;
        if (s_out_last && m_first_last < 0) m_first_last = cyc;
      end
      cyc++;
      if (words_q.size() == 0 && got_q.size() >= exp_q.size()) done = 1;
    end
    @(posedge clk); #1;
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s timeout: observed %0d beats expected %0d", tag, got_q.size(), exp_q.size());
    end
    check({tag, " beat count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s beat%0d data", tag, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s beat%0d last", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
  endtask

  initial begin
    sel = 0; reset = 1'b1;
    d_in_valid = 1'b1; d_in_data = 32'h5A5A5A5A; d_out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      check("rst in_ready8",  32'(if8.in_ready),  32'd0);
      check("rst out_valid8", 32'(if8.out_valid), 32'd0);
      check("rst busy8",      32'(if8.busy),      32'd0);
      check("rst in_ready1",  32'(if1.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; d_in_valid = 1'b0;
    @(negedge clk);
    check("post-rst in_ready",  32'(s_in_ready), 32'd1);
    check("post-rst out_data",  s_out_data,      32'd0);
    check("post-rst out_last",  32'(s_out_last), 32'd0);
    check("post-rst out_valid", 32'(s_out_valid), 32'd0);

    // Single word, free-flowing output
    words_q = '{32'hA1B2C3D4};
    run("single", 0, 8, 1, 50);
    check("single first-beat latency", 32'(m_first_beat - m_first_load), 32'd1);
    check("single last-beat latency",  32'(m_last_beat - m_first_load),  32'd4);

    // Back-pressure
    words_q = '{32'hA1B2C3D4};
    run("bp", 0, 8, 2, 100);

    // Back-to-back words, no bubble
    words_q = '{32'h0000FFFF, 32'h12345678};
    run("b2b", 0, 8, 1, 50);
    check("b2b second load at first last", 32'(m_second_load), 32'(m_first_last));
    check("b2b span",         32'(m_last_beat - m_first_load), 32'd8);
    check("b2b valid cycles", 32'(m_valid_cycles), 32'd8);

    // Reset in the middle of a word
    sel = 0;
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_data = 32'hDEADBEEF; d_out_ready = 1'b1;
    @(negedge clk);
    check("mid-rst load ready", 32'(s_in_ready), 32'd1);
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_in_data = $urandom;
    @(negedge clk);
    check("mid-rst beat1", s_out_data, 32'hEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-rst beat2", s_out_data, 32'hBE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid-rst in_ready gated", 32'(s_in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid-rst out_valid", 32'(s_out_valid), 32'd0);
      check("mid-rst busy",      32'(s_busy),      32'd0);
    end
    words_q = '{32'h00000001};
    run("after-rst", 0, 8, 1, 50);

    // Single-bit beats
    words_q = '{32'h80000001};
    run("ser1", 1, 1, 1, 100);
    check("ser1 last-beat latency", 32'(m_last_beat - m_first_load), 32'd32);

    // Randomized words, valid gaps and back-pressure
    words_q.delete();
    repeat (12) words_q.push_back($urandom);
    run("rand8", 0, 8, 3, 2000);
    words_q.delete();
    repeat (3) words_q.push_back($urandom);
    run("rand1", 1, 1, 3, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
